condexec_pipe: RTL
==================

Name: condexec_pipe

Overview:
- Decode-to-execute successor to the single-cycle control decoder.
- Registers decoded control signals into the E stage, with stall and flush.
- Holds the architectural NZCV flags register and evaluates the 4-bit ARM condition field in E.
- Gates the E-stage side effects (register write, memory write, PC redirect, flag update) by the condition result. Sits between the decoder and the datapath/hazard unit of the 5-stage pipeline.

Parameters:
- ALUCTRL_W, 3: width of the ALU control field carried through the pipe.
- NV_AS_AL, 0: 1 makes cond 4'b1111 behave as AL; 0 makes it never execute.
- RESET_FLAGS, 4'b0000: NZCV value loaded on reset, ordered {N,Z,C,V}.
- CNT_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- StallE  input  1  hold the E register and the flags register
- FlushE  input  1  load a bubble into E
- ValidD  input  1  D stage holds a real instruction
- CondD  input  4  condition field, Instr[31:28]
- PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD  input  1 each  decoded controls
- FlagWriteD  input  2  [1] updates N,Z; [0] updates C,V
- ALUControlD  input  ALUCTRL_W  ALU operation
- ALUFlags  input  4  {N,Z,C,V} from the ALU, valid in E
- PCSrcE, RegWriteE, MemWriteE  output  1 each  condition-gated controls
- MemtoRegE, ALUSrcE  output  1 each  registered, ungated
- ALUControlE  output  ALUCTRL_W  registered
- BranchTakenE  output  1  BranchE & CondExE
- CondExE  output  1  condition passed and ValidE
- FlagsE  output  4  current architectural flags

Behaviour:
- Reset (reset=0, asynchronous):
  - All E registers, ValidE and CondE clear to 0.
  - Flags load RESET_FLAGS.
  - Every output is 0 except FlagsE = RESET_FLAGS.
- E register update on each rising clk, in priority order:
  - FlushE=1: bubble. All controls 0, ValidE 0. FlushE wins over StallE.
  - Else StallE=1: hold all E registers.
  - Else: load all D inputs; ValidE takes ValidD.
- Latency: D inputs appear at E outputs one cycle after capture. Gated outputs are combinational from the E registers, FlagsE and CondE.
- Condition evaluation uses the registered flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1.
  - 1111: value of NV_AS_AL.
- CondExE = condpass & ValidE.
- Gated outputs: RegWriteE = RegWriteE_r & CondExE. MemWriteE and PCSrcE are gated the same way. BranchTakenE = BranchE_r & CondExE.
- Flags update at a clock edge when StallE=0 and CondExE=1:
  - FlagWriteE[1]=1 loads N,Z from ALUFlags.
  - FlagWriteE[0]=1 loads C,V from ALUFlags.
  - Otherwise the flags hold. There is no update while stalled, so a stalled flag-setting instruction writes exactly once.
- Back-to-back: a flag-setting instruction in E at cycle t makes the flags visible to the instruction in E at cycle t+1. No internal forwarding is needed.
- A squashed instruction (cond fails) produces no register write, memory write, flag write or PC redirect.
- A bubble never executes, even with cond=AL.
- Reset mid-stall clears everything immediately. Stall and flush are ignored while reset is 0.

Optional Feature:
- Macro CONDEXEC_PIPE_STATS_EN.
- When defined, adds outputs ExecCount and SquashCount, each CNT_W wide.
  - Each cycle with StallE=0 and ValidE=1 increments ExecCount if CondExE, else SquashCount.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Flags after reset: release reset with RESET_FLAGS=4'b0000. Issue ValidD=1, CondD=EQ, RegWriteD=1 → next cycle CondExE=0, RegWriteE=0.
- Flag write then consume:
  - Cycle 1: AL, FlagWriteD=2'b11, ALUFlags=4'b0100 in E → FlagsE=0100 in the next cycle.
  - Cycle 2: following EQ instruction with MemWriteD=1 → MemWriteE=1.
  - Cycle 3: a following NE instruction gives MemWriteE=0.
- Partial flag write: flags 1111; instruction with FlagWriteD=2'b01 and ALUFlags=0000 → flags become 1100.
- Stall and flush:
  - Hold StallE=1 for 3 cycles with a flag-setting instruction in E → flags written once; E outputs stable.
  - Assert FlushE and StallE together → bubble, all gated outputs 0.
- Conditional branch: BranchD=1, CondD=GT.
  - Flags N=1, V=0 → BranchTakenE=0, PCSrcE=0.
  - Flags N=1, V=1, Z=0 → BranchTakenE=1.
  - Cond 1111 with NV_AS_AL=0 → never taken.
- With CONDEXEC_PIPE_STATS_EN and CNT_W=4: 20 executed instructions → ExecCount=15 (saturated). 3 squashed instructions → SquashCount=3. Asynchronous reset mid-run → both counters 0.

Source files
------------

// File: rtl/condexec_pipe.sv
// Decode-to-execute pipeline register with NZCV flags and ARM condition evaluation in E.
// Optional statistics counters are enabled by defining CONDEXEC_PIPE_STATS_EN.
module condexec_pipe #(
    parameter int unsigned ALUCTRL_W   = 3,
    parameter bit          NV_AS_AL    = 1'b0,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ValidD,
    input  logic [3:0]           CondD,
    input  logic                 PCSrcD,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 MemtoRegD,
    input  logic                 ALUSrcD,
    input  logic                 BranchD,
    input  logic [1:0]           FlagWriteD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [3:0]           ALUFlags,
    output logic                 PCSrcE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 MemtoRegE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 BranchTakenE,
    output logic                 CondExE,
    output logic [3:0]           FlagsE
`ifdef CONDEXEC_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]     ExecCount,
    output logic [CNT_W-1:0]     SquashCount
`endif
);

    logic                 validQ;
    logic [3:0]           condQ;
    logic                 pcSrcQ;
    logic                 regWriteQ;
    logic                 memWriteQ;
    logic                 memtoRegQ;
    logic                 aluSrcQ;
    logic                 branchQ;
    logic [1:0]           flagWriteQ;
    logic [ALUCTRL_W-1:0] aluControlQ;
    logic [3:0]           flagsQ;
    logic                 condPass;
    logic                 flagN, flagZ, flagC, flagV;

    // E register: flush beats stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ      <= 1'b0;
            condQ       <= 4'b0000;
            pcSrcQ      <= 1'b0;
            regWriteQ   <= 1'b0;
            memWriteQ   <= 1'b0;
            memtoRegQ   <= 1'b0;
            aluSrcQ     <= 1'b0;
            branchQ     <= 1'b0;
            flagWriteQ  <= 2'b00;
            aluControlQ <= '0;
        end else if (FlushE) begin
            validQ      <= 1'b0;
            condQ       <= 4'b0000;
            pcSrcQ      <= 1'b0;
            regWriteQ   <= 1'b0;
            memWriteQ   <= 1'b0;
            memtoRegQ   <= 1'b0;
            aluSrcQ     <= 1'b0;
            branchQ     <= 1'b0;
            flagWriteQ  <= 2'b00;
            aluControlQ <= '0;
        end else if (!StallE) begin
            validQ      <= ValidD;
            condQ       <= CondD;
            pcSrcQ      <= PCSrcD;
            regWriteQ   <= RegWriteD;
            memWriteQ   <= MemWriteD;
            memtoRegQ   <= MemtoRegD;
            aluSrcQ     <= ALUSrcD;
            branchQ     <= BranchD;
            flagWriteQ  <= FlagWriteD;
            aluControlQ <= ALUControlD;
        end
    end

    assign {flagN, flagZ, flagC, flagV} = flagsQ;

    always_comb begin
        condPass = 1'b0;
        case (condQ)
            4'h0:    condPass = flagZ;
            4'h1:    condPass = !flagZ;
            4'h2:    condPass = flagC;
            4'h3:    condPass = !flagC;
            4'h4:    condPass = flagN;
            4'h5:    condPass = !flagN;
            4'h6:    condPass = flagV;
            4'h7:    condPass = !flagV;
            4'h8:    condPass = flagC && !flagZ;
            4'h9:    condPass = !flagC || flagZ;
            4'hA:    condPass = (flagN == flagV);
            4'hB:    condPass = (flagN != flagV);
            4'hC:    condPass = !flagZ && (flagN == flagV);
            4'hD:    condPass = flagZ || (flagN != flagV);
            4'hE:    condPass = 1'b1;
            default: condPass = NV_AS_AL;
        endcase
    end

    assign CondExE      = condPass && validQ;
    assign PCSrcE       = pcSrcQ && CondExE;
    assign RegWriteE    = regWriteQ && CondExE;
    assign MemWriteE    = memWriteQ && CondExE;
    assign BranchTakenE = branchQ && CondExE;
    assign MemtoRegE    = memtoRegQ;
    assign ALUSrcE      = aluSrcQ;
    assign ALUControlE  = aluControlQ;
    assign FlagsE       = flagsQ;

    // Holding while stalled keeps a stalled flag-setter to a single write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flagsQ <= RESET_FLAGS;
        end else if (!StallE && CondExE) begin
            if (flagWriteQ[1]) flagsQ[3:2] <= ALUFlags[3:2];
            if (flagWriteQ[0]) flagsQ[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef CONDEXEC_PIPE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ExecCount   <= '0;
            SquashCount <= '0;
        end else if (!StallE && validQ) begin
            if (CondExE) begin
                if (ExecCount != '1) ExecCount <= ExecCount + 1'b1;
            end else begin
                if (SquashCount != '1) SquashCount <= SquashCount + 1'b1;
            end
        end
    end
`endif

endmodule
